regfile_dump: RTL and testbench

- Reader-side sequencer for the register file's read port.
- On a start pulse it walks register indices 0..NUM_REGS-1, fetches each 32-bit value through one synchronous read port and serialises it as bytes onto a valid/ready byte stream.
- The byte stream feeds the UART transmitter so the host sees the full architectural register state after each interactive instruction.
- Sits between the register file (port B or a dedicated debug port) and the UART TX path.

---
 rtl/regfile_dump.sv | 120 ++++++++++++
 tb/tb_regfile_dump.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Register-file dump sequencer: walks registers 0..NUM_REGS-1 through one synchronous
// read port and streams each 32-bit value as four little-endian bytes on a valid/ready port.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// ISSUE   | rdAddr presents idx to the register file
// CAPTURE | rdData valid; load shift register, clear byte count
// SEND    | offer shift[7:0]; shift and count on each accepted byte
// DONE    | one-cycle done pulse, then back to IDLE
module regfile_dump #(
  parameter int NUM_REGS     = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rdAddr,
  input  logic [31:0] rdData,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        busy,
  output logic        done
);

  if (READ_LATENCY != 1) begin : g_bad_latency
    $error("regfile_dump supports READ_LATENCY == 1 only");
  end
  if (NUM_REGS < 1 || NUM_REGS > 32) begin : g_bad_num_regs
    $error("regfile_dump NUM_REGS must be in 1..32");
  end

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        shift_d    = rdData;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (txReady) begin
          shift_d    = shift_q >> 8;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_DONE: begin
        // park the read address at 0 so an idle port looks like a fresh reset
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // idx is already registered, so it doubles as the read address
  assign rdAddr  = idx_q;
  assign txData  = shift_q[7:0];
  assign txValid = (state_q == S_SEND);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

  a_tx_hold : assert property (@(posedge clk)
    (!reset && !$past(reset) && $past(txValid && !txReady))
      |-> (txValid && (txData == $past(txData))))
    else $error("txValid/txData changed while stalled");

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: behavioural register-file model and byte-stream reference,
// randomised register contents and txReady back-pressure.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start_1;
  logic [4:0]  rd_addr, rd_addr_1;
  logic [31:0] rd_data, rd_data_1;
  logic [7:0]  tx_data, tx_data_1;
  logic        tx_valid, tx_valid_1;
  logic        tx_ready, tx_ready_1;
  logic        busy, busy_1;
  logic        done, done_1;

  logic [31:0] rf  [32];
  logic [31:0] rf1 [32];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         done_cnt;
  int         done_cyc;
  int         first_v;

  regfile_dump #(.NUM_REGS(32), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .rdAddr(rd_addr), .rdData(rd_data),
    .txData(tx_data), .txValid(tx_valid), .txReady(tx_ready), .busy(busy), .done(done)
  );

  regfile_dump #(.NUM_REGS(1), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_1), .rdAddr(rd_addr_1), .rdData(rd_data_1),
    .txData(tx_data_1), .txValid(tx_valid_1), .txReady(tx_ready_1), .busy(busy_1), .done(done_1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_data   <= rf[rd_addr];
    rd_data_1 <= rf1[rd_addr_1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference byte stream: registers ascending, each little-endian
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int r = 0; r < n; r++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'((rf[r] >> (8 * b)) & 32'hff));
  endtask

  // stream monitor for the 32-register instance
  initial begin
    logic       pend;
    logic [7:0] pend_data;
    pend = 1'b0;
    pend_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(pend_data));
        end
        pend      = tx_valid && !tx_ready;
        pend_data = tx_data;
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (tx_valid && first_v < 0) first_v = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic compare_stream(input string tag, input int copies);
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size() * copies));
    for (int i = 0; i < got.size() && i < exp_q.size() * copies; i++)
      check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i % exp_q.size()]));
  endtask

  task automatic dump(input string tag, input bit rnd, input int restart_at);
    int s;
    int k;
    got.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_v  = -1;
    build_expected(32);
    start = 1'b1;
    s = cyc;
    k = 0;
    while (done_cnt == 0 && k < 5000) begin
      tick();
      k++;
      start    = (restart_at > 0) && (cyc == s + restart_at);
      tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    check({tag, "_no_timeout"}, 32'(k < 5000), 32'd1);
    repeat (3) tick();
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    compare_stream(tag, 1);
    if (!rnd) begin
      check({tag, "_first_valid_cyc"}, 32'(first_v), 32'(s + 3));
      check({tag, "_done_cyc"}, 32'(done_cyc), 32'(s + 1 + 6 * 32));
    end
  endtask

  initial begin
    int s;
    int k;
    int last_acc;
    int d1;
    logic [7:0] got1[$];

    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int k;
    int last_acc;
    int d1;
    logic [7:0] got1[$];

    reset = 1'b1;
    start = 1'b0;
    start_1 = 1'b0;
    tx_ready = 1'b1;
    tx_ready_1 = 1'b1;
    done_cnt = 0;
    done_cyc = -1;
    first_v = -1;
    for (int i = 0; i < 32; i++) begin
      rf[i]  = 32'h1122_3300 + 32'(i);
      rf1[i] = '0;
    end
    repeat (3) tick();
    check("rst_rdaddr", 32'(rd_addr), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_txvalid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst1_busy", 32'(busy_1), 32'd0);
    reset = 1'b0;
    tick();

    // full-speed dump of the fixed preload
    dump("full", 1'b0, 0);
    check("full_first_b0", 32'(got[0]), 32'h00);
    check("full_first_b1", 32'(got[1]), 32'h33);
    check("full_first_b3", 32'(got[3]), 32'h11);
    check("full_last_b0", 32'(got[124]), 32'h1f);
    check("full_last_b3", 32'(got[127]), 32'h11);

    // same contents under random back-pressure
    dump("bp", 1'b1, 0);

    // start re-pulsed mid-dump must be ignored
    dump("restart", 1'b0, 5);

    // random contents, random back-pressure
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    dump("rand", 1'b1, 0);

    // abort with reset after the 10th accepted byte
    for (int i = 0; i < 32; i++) rf[i] = 32'h1122_3300 + 32'(i);
    got.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (got.size() < 10 && k < 200) begin
      tick();
      k++;
    end
    check("abort_reach_10", 32'(got.size() >= 10), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_txvalid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdaddr", 32'(rd_addr), 32'd0);
    reset = 1'b0;
    tick();
    dump("after_abort", 1'b0, 0);

    // start held high: back-to-back dumps separated by DONE and IDLE
    got.delete();
    done_cnt = 0;
    done_cyc = -1;
    build_expected(32);
    start = 1'b1;
    s = cyc;
    repeat (300) tick();
    start = 1'b0;
    k = 0;
    while (done_cnt < 2 && k < 1000) begin
      tick();
      k++;
    end
    repeat (5) tick();
    check("b2b_done_count", 32'(done_cnt), 32'd2);
    check("b2b_last_done_cyc", 32'(done_cyc), 32'(s + 194 + 1 + 6 * 32));
    check("b2b_idle_after", 32'(busy), 32'd0);
    compare_stream("b2b", 2);

    // single-register instance
    for (int t = 0; t < 2; t++) begin
      rf1[0] = (t == 0) ? 32'h0 : $urandom;
      got1.delete();
      d1 = -1;
      last_acc = -1;
      start_1 = 1'b1;
      tick();
      start_1 = 1'b0;
      k = 0;
      while (d1 < 0 && k < 40) begin
        check("one_rdaddr", 32'(rd_addr_1), 32'd0);
        if (tx_valid_1 && tx_ready_1) begin
          got1.push_back(tx_data_1);
          last_acc = cyc;
        end
        if (done_1) d1 = cyc;
        tick();
        k++;
      end
      check("one_len", 32'(got1.size()), 32'd4);
      check("one_done_cyc", 32'(d1), 32'(last_acc + 1));
      for (int b = 0; b < 4 && b < got1.size(); b++)
        check("one_byte", 32'(got1[b]), (rf1[0] >> (8 * b)) & 32'hff);
      repeat (2) tick();
      check("one_idle", 32'(busy_1), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
